// File: rtl/lsu_mem_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared encodings for the load/store unit: decoder RSel/WSel
//             codes, FSM state enum, access-size enum, byte-enable constants
//             and the decode helpers used by the LSU datapath.
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

   // RSel load-size codes (match the decoder)
   localparam logic [2:0] LW_SEL  = 3'd0;
   localparam logic [2:0] LH_SEL  = 3'd1;
   localparam logic [2:0] LB_SEL  = 3'd2;
   localparam logic [2:0] LHU_SEL = 3'd3;
   localparam logic [2:0] LBU_SEL = 3'd4;

   // WSel store-size codes (match the decoder)
   localparam logic [1:0] SW_SEL = 2'd0;
   localparam logic [1:0] SH_SEL = 2'd1;
   localparam logic [1:0] SB_SEL = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_WORD = 2'd0,
      SZ_HALF = 2'd1,
      SZ_BYTE = 2'd2
   } acc_size_e;

   typedef struct packed {
      acc_size_e size;
      logic      sext;
   } acc_kind_t;

   localparam logic [3:0] BE_WORD    = 4'b1111;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_BYTE    = 4'b0001;

   // Unknown RSel/WSel codes fall back to a plain word access.
   function automatic acc_kind_t decode_kind(input logic       mem_rw,
                                             input logic [2:0] rsel,
                                             input logic [1:0] wsel);
      acc_kind_t k;
      k.size = SZ_WORD;
      k.sext = 1'b0;
      if (mem_rw) begin
         case (wsel)
            SH_SEL:  k.size = SZ_HALF;
            SB_SEL:  k.size = SZ_BYTE;
            default: k.size = SZ_WORD;
         endcase
      end else begin
         case (rsel)
            LH_SEL:  begin k.size = SZ_HALF; k.sext = 1'b1; end
            LB_SEL:  begin k.size = SZ_BYTE; k.sext = 1'b1; end
            LHU_SEL: k.size = SZ_HALF;
            LBU_SEL: k.size = SZ_BYTE;
            default: k.size = SZ_WORD;
         endcase
      end
      return k;
   endfunction

   function automatic logic is_misaligned(input acc_size_e size, input logic [1:0] lo);
      case (size)
         SZ_HALF: return lo[0];
         SZ_WORD: return (lo != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_if_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_bus_if
//  Purpose  : Single-outstanding word bus between the LSU and data memory.
//  Ports    : bus_req/bus_we/bus_addr/bus_be/bus_wdata  master -> slave
//             bus_ack/bus_rdata                         slave  -> master
//  Revision : 1.0  initial release
// ============================================================================
interface lsu_bus_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ack, bus_rdata
   );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_if_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Purpose  : Combinational lane alignment for both directions.
//             Store side: byte enables + store-data replication.
//             Load side : lane extraction + sign/zero extension.
//  Ports    : st_*  store-side inputs/outputs (request-cycle values)
//             ld_*  load-side inputs/outputs (latched access + bus word)
//  Revision : 1.0  initial release
// ============================================================================
module lsu_align
   import lsu_pkg::*;
(
   input  acc_size_e   st_size,
   input  logic [1:0]  st_addr_lo,
   input  logic [31:0] st_wdata,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata_rep,
   input  acc_size_e   ld_size,
   input  logic        ld_sext,
   input  logic [1:0]  ld_addr_lo,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      st_be        = BE_WORD;
      st_wdata_rep = st_wdata;
      case (st_size)
         SZ_BYTE: begin
            st_be        = BE_BYTE << st_addr_lo;
            st_wdata_rep = {4{st_wdata[7:0]}};
         end
         SZ_HALF: begin
            // addr[0] is ignored here; the trap (if built) catches it earlier
            st_be        = st_addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
            st_wdata_rep = {2{st_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      w_byte = ld_word[7:0];
      case (ld_addr_lo)
         2'd1:    w_byte = ld_word[15:8];
         2'd2:    w_byte = ld_word[23:16];
         2'd3:    w_byte = ld_word[31:24];
         default: w_byte = ld_word[7:0];
      endcase
      w_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

      case (ld_size)
         SZ_BYTE: ld_data = {{24{ld_sext & w_byte[7]}}, w_byte};
         SZ_HALF: ld_data = {{16{ld_sext & w_half[15]}}, w_half};
         default: ld_data = ld_word;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_if
//  Purpose  : Load/store unit: one outstanding word-bus access per memory
//             instruction, pipeline stall until ack/timeout/misalign, byte
//             enables, store-data replication and load extension.
//  Ports    : clk, rst                      clock, async active-high reset
//             req_valid/mem_rw/rsel/wsel    decoded memory request
//             addr/wdata                    ALU address, rs2 store data
//             stall                         freeze PC/pipeline
//             rdata/rdata_valid             extended load result
//             bus_err/misalign              one-cycle status pulses in DONE
//             bus                           lsu_bus_if.master
//  Config   : LSU_MISALIGN_TRAP_EN - trap misaligned H/W accesses instead of
//             issuing them with the low address bits ignored.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_mem_if
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        mem_rw,
   input  logic [2:0]  rsel,
   input  logic [1:0]  wsel,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        bus_err,
   output logic        misalign,
   lsu_bus_if.master   bus
);

   localparam logic [1:0] C_S_IDLE  = IDLE;
   localparam logic [1:0] C_S_BUSY  = BUSY;
   localparam logic [1:0] C_S_DONE  = DONE;
   // counter value in the last permitted BUSY cycle
   localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [1:0]  r_state;
   logic [7:0]  r_cnt;
   acc_size_e   r_size;
   logic        r_sext;
   logic [1:0]  r_addr_lo;
   logic        r_bus_req;
   logic        r_bus_we;
   logic [31:0] r_bus_addr;
   logic [3:0]  r_bus_be;
   logic [31:0] r_bus_wdata;
   logic [31:0] r_rdata;
   logic        r_rdata_valid;
   logic        r_bus_err;
   logic        r_misalign;

   acc_kind_t   w_kind;
   logic        w_misal;
   logic [3:0]  w_st_be;
   logic [31:0] w_st_wdata;
   logic [31:0] w_ld_data;

   assign w_kind = decode_kind(mem_rw, rsel, wsel);

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_misal = is_misaligned(w_kind.size, addr[1:0]);
`else
   assign w_misal = 1'b0;
`endif

   lsu_align u_align (
      .st_size      (w_kind.size),
      .st_addr_lo   (addr[1:0]),
      .st_wdata     (wdata),
      .st_be        (w_st_be),
      .st_wdata_rep (w_st_wdata),
      .ld_size      (r_size),
      .ld_sext      (r_sext),
      .ld_addr_lo   (r_addr_lo),
      .ld_word      (bus.bus_rdata),
      .ld_data      (w_ld_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= C_S_IDLE;
         r_cnt         <= 8'd0;
         r_size        <= SZ_WORD;
         r_sext        <= 1'b0;
         r_addr_lo     <= 2'b00;
         r_bus_req     <= 1'b0;
         r_bus_we      <= 1'b0;
         r_bus_addr    <= 32'd0;
         r_bus_be      <= 4'd0;
         r_bus_wdata   <= 32'd0;
         r_rdata       <= 32'd0;
         r_rdata_valid <= 1'b0;
         r_bus_err     <= 1'b0;
         r_misalign    <= 1'b0;
      end else begin
         r_rdata_valid <= 1'b0;
         r_bus_err     <= 1'b0;
         r_misalign    <= 1'b0;
         case (r_state)
            C_S_IDLE: begin
               if (req_valid) begin
                  r_size      <= w_kind.size;
                  r_sext      <= w_kind.sext;
                  r_addr_lo   <= addr[1:0];
                  r_bus_we    <= mem_rw;
                  r_bus_addr  <= {addr[31:2], 2'b00};
                  r_bus_be    <= mem_rw ? w_st_be : BE_WORD;
                  r_bus_wdata <= w_st_wdata;
                  r_cnt       <= 8'd0;
                  if (w_misal) begin
                     r_state    <= C_S_DONE;
                     r_misalign <= 1'b1;
                     r_rdata    <= 32'd0;
                  end else begin
                     r_state   <= C_S_BUSY;
                     r_bus_req <= 1'b1;
                  end
               end
            end
            C_S_BUSY: begin
               // ack is tested first so it wins over a simultaneous timeout
               if (bus.bus_ack) begin
                  r_state   <= C_S_DONE;
                  r_bus_req <= 1'b0;
                  if (!r_bus_we) begin
                     r_rdata       <= w_ld_data;
                     r_rdata_valid <= 1'b1;
                  end
               end else if (r_cnt == C_TO_LAST) begin
                  r_state   <= C_S_DONE;
                  r_bus_req <= 1'b0;
                  r_bus_err <= 1'b1;
                  r_rdata   <= 32'd0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            C_S_DONE: r_state <= C_S_IDLE;
            default:  r_state <= C_S_IDLE;
         endcase
      end
   end

   // Request-cycle term is combinational so the core freezes immediately;
   // rst gating keeps stall low while the reset is held.
   assign stall = ~rst & (((r_state == C_S_IDLE) & req_valid) | (r_state == C_S_BUSY));

   assign rdata         = r_rdata;
   assign rdata_valid   = r_rdata_valid;
   assign bus_err       = r_bus_err;
   assign misalign      = r_misalign;
   assign bus.bus_req   = r_bus_req;
   assign bus.bus_we    = r_bus_we;
   assign bus.bus_addr  = r_bus_addr;
   assign bus.bus_be    = r_bus_be;
   assign bus.bus_wdata = r_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_if.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_mem_if
//  Purpose  : Self-checking bench for lsu_mem_if: directed cases plus random
//             transactions checked against a byte-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_mem_if;

   localparam int TO = 7;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        mem_rw;
   logic [2:0]  rsel;
   logic [1:0]  wsel;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        bus_err;
   logic        misalign;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] ref_rdata = 32'd0;

   lsu_bus_if bus_if ();

   lsu_mem_if #(.TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .mem_rw      (mem_rw),
      .rsel        (rsel),
      .wsel        (wsel),
      .addr        (addr),
      .wdata       (wdata),
      .stall       (stall),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .bus_err     (bus_err),
      .misalign    (misalign),
      .bus         (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: access width in bytes and signedness from the codes
   function automatic int ref_bytes(input logic rw, input logic [2:0] rs, input logic [1:0] ws);
      if (rw) return (ws == 2'd1) ? 2 : (ws == 2'd2) ? 1 : 4;
      case (rs)
         3'd1, 3'd3: return 2;
         3'd2, 3'd4: return 1;
         default:    return 4;
      endcase
   endfunction

   task automatic run_txn(input logic rw, input logic [2:0] rs, input logic [1:0] ws,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int ack_at, input logic [31:0] rd, input logic hold);
      int          n, base, nbusy;
      logic        sgn, ex_misal, ex_err;
      logic [3:0]  ex_be;
      logic [31:0] ex_wd, sh, ld;
      n    = ref_bytes(rw, rs, ws);
      sgn  = !rw && (rs == 3'd1 || rs == 3'd2);
      base = (int'(a[1:0]) / n) * n;
      ex_be = 4'b0000;
      ex_wd = 32'd0;
      for (int i = 0; i < 4; i++) begin
         ex_be[i]        = rw ? (i >= base && i < base + n) : 1'b1;
         ex_wd[8*i +: 8] = wd[8*(i % n) +: 8];
      end
`ifdef LSU_MISALIGN_TRAP_EN
      ex_misal = (int'(a[1:0]) % n) != 0;
`else
      ex_misal = 1'b0;
`endif
      sh = rd >> (8 * base);
      if (n == 1)      ld = sgn ? {{24{sh[7]}}, sh[7:0]}   : {24'd0, sh[7:0]};
      else if (n == 2) ld = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
      else             ld = rd;
      ex_err = !ex_misal && !(ack_at >= 1 && ack_at <= TO);
      nbusy  = ex_misal ? 0 : (ex_err ? TO : ack_at);

      req_valid = 1'b1; mem_rw = rw; rsel = rs; wsel = ws; addr = a; wdata = wd;
      #1 check_value("stall_req", 32'(stall), 32'd1);
      @(posedge clk); @(negedge clk);
      if (!hold) begin
         req_valid = 1'b0; addr = $urandom; wdata = $urandom;
      end
      for (int c = 1; c <= nbusy; c++) begin
         check_value("busy_req", 32'(bus_if.bus_req), 32'd1);
         check_value("busy_stall", 32'(stall), 32'd1);
         check_value("busy_we", 32'(bus_if.bus_we), 32'(rw));
         check_value("busy_addr", bus_if.bus_addr, {a[31:2], 2'b00});
         check_value("busy_be", 32'(bus_if.bus_be), 32'(ex_be));
         if (rw) check_value("busy_wdata", bus_if.bus_wdata, ex_wd);
         check_value("busy_rvalid", 32'(rdata_valid), 32'd0);
         bus_if.bus_ack   = (c == ack_at);
         bus_if.bus_rdata = (c == ack_at) ? rd : $urandom;
         @(posedge clk); @(negedge clk);
         bus_if.bus_ack = 1'b0;
      end
      if (ex_misal || ex_err)  ref_rdata = 32'd0;
      else if (!rw)            ref_rdata = ld;
      check_value("done_stall", 32'(stall), 32'd0);
      check_value("done_req", 32'(bus_if.bus_req), 32'd0);
      check_value("done_rvalid", 32'(rdata_valid), 32'(!rw && !ex_misal && !ex_err));
      check_value("done_err", 32'(bus_err), 32'(ex_err));
      check_value("done_misal", 32'(misalign), 32'(ex_misal));
      check_value("done_rdata", rdata, ref_rdata);
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      #1;
      check_value("idle_stall", 32'(stall), 32'd0);
      check_value("idle_rvalid", 32'(rdata_valid), 32'd0);
      check_value("idle_err", 32'(bus_err), 32'd0);
      check_value("idle_rdata", rdata, ref_rdata);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; mem_rw = 1'b0; rsel = 3'd0; wsel = 2'd0;
      addr = 32'd0; wdata = 32'd0;
      bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'd0;
      repeat (2) @(negedge clk);
      check_value("rst_stall", 32'(stall), 32'd0);
      check_value("rst_req", 32'(bus_if.bus_req), 32'd0);
      check_value("rst_rdata", rdata, 32'd0);
      check_value("rst_flags", {29'd0, rdata_valid, bus_err, misalign}, 32'd0);
      check_value("rst_bus", {bus_if.bus_addr[27:0], bus_if.bus_be}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // LB at 0x103, ack in first BUSY cycle
      run_txn(1'b0, 3'd2, 2'd0, 32'h0000_0103, 32'd0, 1, 32'h80FF_1234, 1'b0);
      // SH at 0x202
      run_txn(1'b1, 3'd0, 2'd1, 32'h0000_0202, 32'h0000_ABCD, 1, 32'd0, 1'b0);
      // LHU at 0x002, ack after 5 wait cycles; req_valid held into DONE
      run_txn(1'b0, 3'd3, 2'd0, 32'h0000_0002, 32'd0, 6, 32'h9876_5432, 1'b1);
      // timeout with no ack, then ack exactly in the last allowed cycle
      run_txn(1'b0, 3'd0, 2'd0, 32'h0000_0040, 32'd0, 0, 32'hDEAD_BEEF, 1'b0);
      run_txn(1'b0, 3'd0, 2'd0, 32'h0000_0040, 32'd0, TO, 32'hCAFE_F00D, 1'b0);
      // LW at 0x001: trapped or issued depending on build
      run_txn(1'b0, 3'd0, 2'd0, 32'h0000_0001, 32'd0, 2, 32'h1122_3344, 1'b0);
      // invalid codes behave as word accesses
      run_txn(1'b0, 3'd6, 2'd0, 32'h0000_0010, 32'd0, 1, 32'h8000_0001, 1'b0);
      run_txn(1'b1, 3'd0, 2'd3, 32'h0000_0014, 32'h1234_5678, 3, 32'd0, 1'b0);

      for (int k = 0; k < 40; k++) begin
         run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 $urandom, $urandom, $urandom_range(0, TO + 1), $urandom,
                 1'($urandom_range(0, 1)));
      end

      // reset in the middle of BUSY, then a stray late ack
      req_valid = 1'b1; mem_rw = 1'b0; rsel = 3'd0; addr = 32'h0000_0300;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      check_value("pre_rst_req", 32'(bus_if.bus_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_value("arst_req", 32'(bus_if.bus_req), 32'd0);
      check_value("arst_stall", 32'(stall), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      ref_rdata = 32'd0;
      bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h5555_AAAA;
      @(posedge clk); @(negedge clk);
      bus_if.bus_ack = 1'b0;
      check_value("late_rvalid", 32'(rdata_valid), 32'd0);
      check_value("late_req", 32'(bus_if.bus_req), 32'd0);
      check_value("late_stall", 32'(stall), 32'd0);
      check_value("late_rdata", rdata, ref_rdata);
      @(negedge clk);
      // a normal access still works after the reset
      run_txn(1'b0, 3'd4, 2'd0, 32'h0000_0301, 32'd0, 2, 32'h0000_F100, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lsu_mem_if.md
# lsu_mem_if

Load/store unit sitting directly downstream of the instruction decoder/control block, between the execute stage (ALU address, rs2 data) and the data-memory bus. It consumes the decoder's MemRW, RSel and WSel codes and performs a single outstanding word-bus transaction per memory instruction. It generates byte enables and lane-replicated store data, and sign/zero-extends load data for the WBSel=0 writeback path. It also stalls the core until the bus acknowledges, or until a timeout or misalignment ends the access.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum BUSY cycles without bus_ack before abort (1..255)

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  EX stage presents a load/store this cycle
- mem_rw  in  1  1 = store, 0 = load (MemRW encoding)
- rsel  in  3  load size: 0 LW, 1 LH, 2 LB, 3 LHU, 4 LBU
- wsel  in  2  store size: 0 SW, 1 SH, 2 SB
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data (rs2)
- stall  out  1  freeze PC/pipeline
- rdata  out  32  extended load result
- rdata_valid  out  1  rdata valid (loads only)
- bus_err  out  1  timeout pulse
- misalign  out  1  misaligned-access pulse
- bus_req  out  1  bus request, held until ack
- bus_we  out  1  bus write
- bus_addr  out  32  word address (addr[1:0] = 0)
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  bus completion, one cycle
- bus_rdata  in  32  read word, valid with bus_ack

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE with req_valid:
  - Latch mem_rw, size, addr and wdata.
  - Go to BUSY. Go to DONE instead when a misalignment trap fires (see Configuration).
- BUSY:
  - bus_req = 1, with registered bus_we, bus_addr, bus_be and bus_wdata held stable.
  - On bus_ack: capture the extended load data and go to DONE.
  - A timeout counter increments each BUSY cycle. When it reaches TIMEOUT_CYCLES with no ack: go to DONE with bus_err, rdata = 0.
  - If bus_ack and timeout occur in the same cycle, the ack wins.
- DONE:
  - Lasts exactly one cycle, then returns to IDLE.
  - req_valid is ignored in DONE; it is the same instruction retiring.
- Byte enables:
  - SB: be = 0001 << addr[1:0], wdata[7:0] replicated ×4.
  - SH: be = addr[1] ? 1100 : 0011, wdata[15:0] replicated ×2.
  - SW: be = 1111.
  - Loads: be = 1111.
- Load extraction:
  - Select the byte lane by addr[1:0] and the halfword by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Invalid codes (rsel 5–7, wsel 3) are treated as word accesses.

## Timing
- Reset value of every output is 0; reset state is IDLE with the counter at 0.
- stall = (IDLE & req_valid) | BUSY. The IDLE term is combinational so the core freezes in the request cycle. stall = 0 in DONE.
- rdata_valid, bus_err and misalign are registered and high only during DONE.
- rdata holds its value outside DONE.
- Minimum latency, ack in the first BUSY cycle: request cycle (IDLE), BUSY, DONE = 3 cycles. Each wait cycle adds 1.
- Asserting rst mid-transaction drops bus_req immediately and discards the access. A bus_ack arriving after reset release is ignored in IDLE.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - An LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]≠0, is not issued.
  - The FSM goes IDLE→DONE with misalign = 1 and rdata = 0 (2-cycle stall window).
- Undefined:
  - misalign is tied 0.
  - Low address bits beyond natural alignment are ignored (halfword uses addr[1], word uses none). The access is issued normally.

## Structure
- Package lsu_pkg holds:
  - the RSel encodings (LW_SEL..LBU_SEL) and WSel encodings (SW_SEL..SB_SEL), matching the decoder;
  - the state enum {IDLE, BUSY, DONE};
  - the byte-enable constants.
- One combinational sub-module, lsu_align, does both directions of the lane alignment:
  - store path: byte-enable generation and store-data replication;
  - load path: lane extraction and extension.
- The FSM, timeout counter and output registers live in lsu_mem_if.

## Test plan
- LB at addr 0x103, bus_rdata 0x80FF_1234, ack in BUSY cycle 1 → bus_addr 0x100, be 1111, rdata 0xFFFF_FF80, rdata_valid in cycle 3, stall high for 2 cycles.
- SH at 0x202, wdata 0x0000_ABCD → bus_we 1, bus_addr 0x200, be 1100, bus_wdata 0xABCD_ABCD, rdata_valid stays 0.
- LHU at 0x002 with ack delayed 5 cycles → bus_req held 6 cycles, outputs stable, rdata 0x0000_xxxx zero-extended, stall drops in DONE.
- TIMEOUT_CYCLES=4, no ack → bus_err pulse after 4 BUSY cycles, rdata 0. Rerun with ack in the 4th BUSY cycle → no bus_err, data returned.
- With LSU_MISALIGN_TRAP_EN, LW at 0x001 → bus_req never asserted, misalign pulse in DONE. Without the macro → bus_addr 0x000, be 1111, normal completion.
- Assert rst during BUSY → bus_req and stall go to 0 asynchronously. A late bus_ack after release produces no rdata_valid.
